// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
//   Shared constants for the board I/O conditioning blocks.
//   IO_SW_WIDTH    : number of board switches feeding the core
//   IO_SYNC_STAGES : depth of the metastability synchroniser
//   IO_DB_CYCLES   : stable synchronised cycles needed to accept a change
//   db_cnt_w()     : width of a debounce counter able to hold 0..db
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int IO_SW_WIDTH    = 32;
    localparam int IO_SYNC_STAGES = 2;
    localparam int IO_DB_CYCLES   = 16;

    function automatic int db_cnt_w(input int db);
        return $clog2(db + 1);
    endfunction

endpackage

// File: rtl/sw_db_cell.sv
// -----------------------------------------------------------------------------
// sw_db_cell
//   One switch bit: synchroniser chain, debounce counter, stable output
//   register and registered rise/fall pulses.
//   Ports:
//     i_clk    : system clock
//     i_reset  : asynchronous active-low reset
//     i_raw    : raw switch level, asynchronous to i_clk
//     o_stable : debounced level
//     o_rise   : one-cycle pulse when o_stable goes 0->1
//     o_fall   : one-cycle pulse when o_stable goes 1->0
//     o_busy   : a change is being counted (counter non-zero)
// -----------------------------------------------------------------------------
module sw_db_cell
    import io_pkg::*;
#(
    parameter int SYNC_STAGES = IO_SYNC_STAGES,
    parameter int DB_CYCLES   = IO_DB_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int             CW       = db_cnt_w(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised level agrees with the accepted level
    // restarts the count, so bouncing never accumulates. The counter stops at
    // CNT_LAST: that cycle commits the new level instead of incrementing.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = s;
            rise_d   = s;
            fall_d   = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign o_busy   = (cnt_q != '0);

endmodule

// File: rtl/io_sw_debounce.sv
// -----------------------------------------------------------------------------
// io_sw_debounce
//   Conditions the board switch word before it reaches the core's i_io_sw.
//   Each bit is synchronised and debounced independently.
//   Ports:
//     i_clk     : system clock, all state on rising edge
//     i_reset   : asynchronous active-low reset; its release is expected to be
//                 already synchronised to i_clk by the system top, so no extra
//                 release stages are added here (keeps the release latency at
//                 exactly SYNC_STAGES + DB_CYCLES)
//     i_sw_raw  : raw switch levels, asynchronous to i_clk
//     o_io_sw   : debounced switch word
//     o_sw_rise : per-bit one-cycle pulse on 0->1 of o_io_sw
//     o_sw_fall : per-bit one-cycle pulse on 1->0 of o_io_sw
//     o_busy    : any bit has a change in progress
// -----------------------------------------------------------------------------
module io_sw_debounce
    import io_pkg::*;
#(
    parameter int WIDTH       = IO_SW_WIDTH,
    parameter int SYNC_STAGES = IO_SYNC_STAGES,
    parameter int DB_CYCLES   = IO_DB_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_io_sw,
    output logic [WIDTH-1:0] o_sw_rise,
    output logic [WIDTH-1:0] o_sw_fall,
    output logic             o_busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("io_sw_debounce: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("io_sw_debounce: DB_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] busy_w;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        sw_db_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_cell (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_raw    (i_sw_raw[k]),
            .o_stable (o_io_sw[k]),
            .o_rise   (o_sw_rise[k]),
            .o_fall   (o_sw_fall[k]),
            .o_busy   (busy_w[k])
        );
    end

    assign o_busy = |busy_w;

endmodule

// File: tb/tb_io_sw_debounce.sv
module tb_io_sw_debounce;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_sw_raw;
    logic [31:0] o_io_sw;
    logic [31:0] o_sw_rise;
    logic [31:0] o_sw_fall;
    logic        o_busy;

    io_sw_debounce #(
        .WIDTH       (32),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_sw_raw  (i_sw_raw),
        .o_io_sw   (o_io_sw),
        .o_sw_rise (o_sw_rise),
        .o_sw_fall (o_sw_fall),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One record: what to drive before an edge, and what must be seen after it.
    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] raw;
        logic [31:0] sw;
        logic [31:0] rise;
        logic [31:0] fall;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total;
    int   bad;

    function automatic void add(input string n, input logic r, input logic [31:0] raw,
                                input logic [31:0] sw, input logic [31:0] rise,
                                input logic [31:0] fall, input logic b);
        vec_t v;
        v.name = n; v.rst = r; v.raw = raw;
        v.sw = sw; v.rise = rise; v.fall = fall; v.busy = b;
        vecs.push_back(v);
    endfunction

    // Seven edges after a single raw step (reset released): two sync edges,
    // three counting edges with busy, commit on edge 6, pulse gone on edge 7.
    function automatic void step_seq(input string n, input logic [31:0] raw,
                                     input logic [31:0] old_sw, input logic [31:0] new_sw);
        add(n, 1'b1, raw, old_sw, 32'h0, 32'h0, 1'b0);
        add(n, 1'b1, raw, old_sw, 32'h0, 32'h0, 1'b0);
        add(n, 1'b1, raw, old_sw, 32'h0, 32'h0, 1'b1);
        add(n, 1'b1, raw, old_sw, 32'h0, 32'h0, 1'b1);
        add(n, 1'b1, raw, old_sw, 32'h0, 32'h0, 1'b1);
        add(n, 1'b1, raw, new_sw, new_sw & ~old_sw, old_sw & ~new_sw, 1'b0);
        add(n, 1'b1, raw, new_sw, 32'h0, 32'h0, 1'b0);
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge i_clk);
            #2;
            i_reset  = vecs[i].rst;
            i_sw_raw = vecs[i].raw;
            exp_q.push_back(vecs[i]);
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        i_reset  = 1'b0;
        i_sw_raw = 32'hFFFF_FFFF;

        fork
            forever begin
                vec_t e;
                @(posedge i_clk);
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({o_io_sw, o_sw_rise, o_sw_fall, o_busy} !==
                        {e.sw, e.rise, e.fall, e.busy}) begin
                        bad++;
                        $display("FAIL %s: got sw=%h rise=%h fall=%h busy=%b, want sw=%h rise=%h fall=%h busy=%b",
                                 e.name, o_io_sw, o_sw_rise, o_sw_fall, o_busy,
                                 e.sw, e.rise, e.fall, e.busy);
                    end
                end
            end
        join_none

        // 1: held in reset with all switches high, then release
        for (int i = 0; i < 3; i++) add("rst_hold", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        step_seq("rst_release", 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        step_seq("all_low",     32'h0,         32'hFFFF_FFFF, 32'h0);

        // 2: clean step on bit 3
        step_seq("clean_step", 32'h0000_0008, 32'h0, 32'h0000_0008);

        // 3: bit 0 glitch of three cycles, one short of acceptance
        add("glitch", 1'b1, 32'h09, 32'h08, 32'h0, 32'h0, 1'b0);
        add("glitch", 1'b1, 32'h09, 32'h08, 32'h0, 32'h0, 1'b0);
        add("glitch", 1'b1, 32'h09, 32'h08, 32'h0, 32'h0, 1'b1);
        add("glitch", 1'b1, 32'h08, 32'h08, 32'h0, 32'h0, 1'b1);
        add("glitch", 1'b1, 32'h08, 32'h08, 32'h0, 32'h0, 1'b1);
        add("glitch", 1'b1, 32'h08, 32'h08, 32'h0, 32'h0, 1'b0);
        add("glitch", 1'b1, 32'h08, 32'h08, 32'h0, 32'h0, 1'b0);

        // 4: bit 7 bounces 1,0,1,0,1 then holds; commit 6 edges after last rise
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b0);
        add("bounce", 1'b1, 32'h08, 32'h08, 32'h0,  32'h0, 1'b0);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b1);
        add("bounce", 1'b1, 32'h08, 32'h08, 32'h0,  32'h0, 1'b0);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b1);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b0);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b1);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b1);
        add("bounce", 1'b1, 32'h88, 32'h08, 32'h0,  32'h0, 1'b1);
        add("bounce", 1'b1, 32'h88, 32'h88, 32'h80, 32'h0, 1'b0);
        add("bounce", 1'b1, 32'h88, 32'h88, 32'h0,  32'h0, 1'b0);

        // 5: reach F0, then swap to 0F in one step
        step_seq("mix_pre", 32'hF0, 32'h88, 32'hF0);
        step_seq("mixed",   32'h0F, 32'hF0, 32'h0F);

        // 6 setup: back to zero, then bit 1 counts to 2
        step_seq("pre6", 32'h0, 32'h0F, 32'h0);
        add("cnt6", 1'b1, 32'h02, 32'h0, 32'h0, 32'h0, 1'b0);
        add("cnt6", 1'b1, 32'h02, 32'h0, 32'h0, 32'h0, 1'b0);
        add("cnt6", 1'b1, 32'h02, 32'h0, 32'h0, 32'h0, 1'b1);
        add("cnt6", 1'b1, 32'h02, 32'h0, 32'h0, 32'h0, 1'b1);
        run_vecs();

        // 6: asynchronous reset in the middle of the count
        @(posedge i_clk);
        #4;
        total++;
        if (o_busy !== 1'b1 || o_io_sw !== 32'h0) begin
            bad++;
            $display("FAIL mid_count: got busy=%b sw=%h, want busy=1 sw=00000000", o_busy, o_io_sw);
        end
        i_reset = 1'b0;
        #1;
        total++;
        if ({o_io_sw, o_sw_rise, o_sw_fall, o_busy} !== 97'h0) begin
            bad++;
            $display("FAIL async_clr: got sw=%h rise=%h fall=%h busy=%b, want all zero",
                     o_io_sw, o_sw_rise, o_sw_fall, o_busy);
        end

        add("rst6", 1'b0, 32'h02, 32'h0, 32'h0, 32'h0, 1'b0);
        add("rst6", 1'b0, 32'h02, 32'h0, 32'h0, 32'h0, 1'b0);
        step_seq("rel6", 32'h02, 32'h0, 32'h02);
        run_vecs();

        repeat (3) @(posedge i_clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
